// File: rtl/fifo_drv_pkg.sv
// fifo_drv_pkg: shared types, constants and helpers for the FIFO stimulus driver
package fifo_drv_pkg;
  typedef enum logic [1:0] {WRITE_ONLY, READ_ONLY, FILL_DRAIN, RANDOM} mode_e;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam int DRAIN_CYCLES = 2;
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction
  function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic en);
    return c + 16'(en && c != 16'hFFFF);
  endfunction
endpackage

// File: rtl/fifo_stim_driver_if.sv
// fifo_stim_driver_if: FIFO write/read request and response signals
interface fifo_stim_driver_if #(parameter int WIDTH = 16);
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] data_in;
  logic             full;
  logic             empty;
  logic             wr_ack;
  logic             overflow;
  logic             underflow;
  modport master (output wr_en, rd_en, data_in, input full, empty, wr_ack, overflow, underflow);
  modport slave (input wr_en, rd_en, data_in, output full, empty, wr_ack, overflow, underflow);
endinterface

// File: rtl/fifo_drv_lfsr.sv
// fifo_drv_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11) with enable and seed load
module fifo_drv_lfsr import fifo_drv_pkg::*; #(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        load,
  input  logic        en,
  output logic [15:0] value
);
  // an all-zero seed would lock the register, so it falls back to the default
  localparam logic [15:0] INIT = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;
  always_ff @(posedge clk)
    value <= load ? INIT : en ? lfsr_next(value) : value;
endmodule

// File: rtl/fifo_stim_driver.sv
// fifo_stim_driver: programmable FIFO traffic generator with saturating response tallies
module fifo_stim_driver import fifo_drv_pkg::*; #(
  parameter int          FIFO_WIDTH = 16,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [15:0]         num_ops,
  input  logic                guard,
  fifo_stim_driver_if.master  bus,
  output logic                busy,
  output logic                done,
  output logic [15:0]         ack_count,
  output logic [15:0]         ovf_count,
  output logic [15:0]         udf_count
);
  localparam int FD_W = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [FD_W-1:0] FD_LAST = FD_W'(FIFO_DEPTH - 1);
  localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);
  state_e state;
  mode_e mode_q;
  logic guard_q;
  logic [15:0] num_q, op_cnt, wr_idx, lfsr;
  logic [1:0] drain_cnt;
  logic [FD_W-1:0] fd_cnt;
  logic fd_rd, wr_raw, rd_raw, wr_go, rd_go, last_op, counting;
  fifo_drv_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .load (rst),
    .en   (state == RUN),
    .value(lfsr)
  );
  always_comb begin
    wr_raw = mode_q == WRITE_ONLY || (mode_q == FILL_DRAIN && !fd_rd) || (mode_q == RANDOM && lfsr[1:0] != 2'b00);
    rd_raw = mode_q == READ_ONLY || (mode_q == FILL_DRAIN && fd_rd) || (mode_q == RANDOM && lfsr[3:2] == 2'b00);
    wr_go = wr_raw && !(guard_q && bus.full);
    rd_go = rd_raw && !(guard_q && bus.empty);
    last_op = op_cnt + 16'd1 == num_q;
    counting = state == RUN || state == DRAIN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mode_q <= WRITE_ONLY;
      guard_q <= 1'b0;
      num_q <= '0;
      op_cnt <= '0;
      wr_idx <= '0;
      drain_cnt <= '0;
      fd_cnt <= '0;
      fd_rd <= 1'b0;
      bus.wr_en <= 1'b0;
      bus.rd_en <= 1'b0;
      bus.data_in <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      ack_count <= '0;
      ovf_count <= '0;
      udf_count <= '0;
    end else begin
      // responses lag requests by a cycle, so DRAIN keeps tallying
      if (counting) begin
        ack_count <= sat_inc(ack_count, bus.wr_ack);
        ovf_count <= sat_inc(ovf_count, bus.overflow);
        udf_count <= sat_inc(udf_count, bus.underflow);
      end
      case (state)
        IDLE: if (start) begin
          mode_q <= mode_e'(mode);
          num_q <= num_ops;
          guard_q <= guard;
          op_cnt <= '0;
          wr_idx <= '0;
          drain_cnt <= '0;
          fd_cnt <= '0;
          fd_rd <= 1'b0;
          ack_count <= '0;
          ovf_count <= '0;
          udf_count <= '0;
          busy <= num_ops != 16'd0;
          done <= num_ops == 16'd0;
          state <= num_ops == 16'd0 ? DONE : RUN;
        end
        RUN: begin
          bus.wr_en <= wr_go;
          bus.rd_en <= rd_go;
          if (wr_go) begin
            bus.data_in <= FIFO_WIDTH'(mode_q == RANDOM ? lfsr : wr_idx);
            wr_idx <= wr_idx + 16'd1;
          end
          op_cnt <= op_cnt + 16'd1;
          fd_cnt <= fd_cnt == FD_LAST ? '0 : fd_cnt + 1'b1;
          fd_rd <= fd_cnt == FD_LAST ? !fd_rd : fd_rd;
          state <= last_op ? DRAIN : RUN;
        end
        DRAIN: begin
          bus.wr_en <= 1'b0;
          bus.rd_en <= 1'b0;
          drain_cnt <= drain_cnt + 2'd1;
          if (drain_cnt == DRAIN_LAST) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_stim_driver.sv
// tb_fifo_stim_driver: scoreboard bench with a behavioural depth-8 FIFO as the responder
module tb_fifo_stim_driver;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, start, guard, busy, done;
  logic [1:0] mode;
  logic [15:0] num_ops, ack_count, ovf_count, udf_count;
  fifo_stim_driver_if #(.WIDTH(16)) bus();
  fifo_stim_driver #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .num_ops(num_ops), .guard(guard),
    .bus(bus), .busy(busy), .done(done),
    .ack_count(ack_count), .ovf_count(ovf_count), .udf_count(udf_count)
  );
  logic [3:0] f_cnt;
  assign bus.full = f_cnt == 4'd8;
  assign bus.empty = f_cnt == 4'd0;
  always @(posedge clk) begin
    if (rst) begin
      f_cnt <= 4'd0;
      bus.wr_ack <= 1'b0;
      bus.overflow <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      bus.wr_ack <= bus.wr_en && !bus.full;
      bus.overflow <= bus.wr_en && bus.full;
      bus.underflow <= bus.rd_en && bus.empty;
      f_cnt <= f_cnt + 4'(bus.wr_en && !bus.full) - 4'(bus.rd_en && !bus.empty);
    end
  end
  int checks = 0, failures = 0;
  int b_ack = 0, b_ovf = 0, b_udf = 0, mon_wr = 0, mon_rd = 0;
  int base_ack, base_ovf, base_udf, base_wr, base_rd, m_wr;
  logic [17:0] exp_q[$];
  logic [17:0] e;
  logic [1:0] m_mode;
  logic m_guard;
  logic [15:0] m_idx, m_lfsr;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    b_ack += int'(bus.wr_ack);
    b_ovf += int'(bus.overflow);
    b_udf += int'(bus.underflow);
    mon_wr += int'(bus.wr_en);
    mon_rd += int'(bus.rd_en);
    if (bus.wr_en || bus.rd_en) begin
      if (exp_q.size() == 0) chk("unexpected_req", {30'd0, bus.wr_en, bus.rd_en}, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("req_wr", 32'(bus.wr_en), 32'(e[17]));
        chk("req_rd", 32'(bus.rd_en), 32'(e[16]));
        if (e[17]) chk("req_data", 32'(bus.data_in), 32'(e[15:0]));
      end
    end
  end
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_lfsr = 16'hACE1;
  endtask
  task automatic issue(input logic [1:0] md, input int n, input logic g, input logic dup);
    mode = md;
    num_ops = 16'(n);
    guard = g;
    start = 1'b1;
    m_mode = md;
    m_guard = g;
    m_idx = 16'd0;
    m_wr = 0;
    base_ack = b_ack; base_ovf = b_ovf; base_udf = b_udf; base_wr = mon_wr; base_rd = mon_rd;
    @(posedge clk);
    #1 start = dup;
    if (dup) begin
      mode = ~md;
      num_ops = 16'd2;
    end
    if (n == 0) begin
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_busy", 32'(busy), 32'd0);
    end else chk("busy_run", 32'(busy), 32'd1);
  endtask
  task automatic predict_slot(input int k);
    logic w, r;
    logic [15:0] d;
    @(posedge clk);
    w = m_mode == 2'd0 || (m_mode == 2'd2 && ((k - 1) / 8) % 2 == 0) || (m_mode == 2'd3 && m_lfsr[1:0] != 2'b00);
    r = m_mode == 2'd1 || (m_mode == 2'd2 && ((k - 1) / 8) % 2 == 1) || (m_mode == 2'd3 && m_lfsr[3:2] == 2'b00);
    if (m_guard) begin
      w = w && !bus.full;
      r = r && !bus.empty;
    end
    d = m_mode == 2'd3 ? m_lfsr : m_idx;
    if (w) begin
      m_idx++;
      m_wr++;
    end
    if (w || r) exp_q.push_back({w, r, d});
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    #1 start = 1'b0;
  endtask
  task automatic finish_run();
    @(posedge clk);
    #1 chk("drain_done_low", 32'(done), 32'd0);
    chk("drain_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1 chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy_low", 32'(busy), 32'd0);
    @(posedge clk);
    #1 chk("done_one_cycle", 32'(done), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask
  task automatic chk_tallies(input int a, input int o, input int u);
    chk("ack_count", 32'(ack_count), 32'(a));
    chk("ovf_count", 32'(ovf_count), 32'(o));
    chk("udf_count", 32'(udf_count), 32'(u));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; num_ops = 16'd0; guard = 1'b0;
    m_lfsr = 16'hACE1; m_mode = 2'd0; m_guard = 1'b0; m_idx = 16'd0;
    do_reset();
    chk("rst_req", {30'd0, bus.wr_en, bus.rd_en}, 32'd0);
    chk("rst_data", 32'(bus.data_in), 32'd0);
    chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
    chk_tallies(0, 0, 0);
    // writes into an empty FIFO; a second start while busy must be ignored
    issue(2'd0, 10, 1'b0, 1'b1);
    for (int k = 1; k <= 10; k++) predict_slot(k);
    finish_run();
    chk_tallies(8, 2, 0);
    chk("wo_wr_cycles", 32'(mon_wr - base_wr), 32'd10);
    repeat (3) @(posedge clk);
    #1 chk("tally_hold", 32'(ack_count), 32'd8);
    do_reset();
    issue(2'd1, 3, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) predict_slot(k);
    finish_run();
    chk_tallies(0, 0, 3);
    issue(2'd1, 3, 1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) predict_slot(k);
    finish_run();
    chk_tallies(0, 0, 0);
    chk("guard_rd_cycles", 32'(mon_rd - base_rd), 32'd0);
    issue(2'd2, 16, 1'b1, 1'b0);
    for (int k = 1; k <= 16; k++) predict_slot(k);
    finish_run();
    chk_tallies(8, 0, 0);
    chk("fd_wr_cycles", 32'(mon_wr - base_wr), 32'd8);
    chk("fd_rd_cycles", 32'(mon_rd - base_rd), 32'd8);
    chk("fd_fifo_empty", 32'(f_cnt), 32'd0);
    do_reset();
    issue(2'd3, 1000, 1'b1, 1'b0);
    for (int k = 1; k <= 1000; k++) predict_slot(k);
    finish_run();
    chk_tallies(b_ack - base_ack, b_ovf - base_ovf, b_udf - base_udf);
    chk("rnd_wr_cycles", 32'(mon_wr - base_wr), 32'(m_wr));
    // reset lands mid-run after five request slots
    issue(2'd0, 20, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) predict_slot(k);
    rst = 1'b1;
    @(posedge clk);
    #1 chk("midrst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk_tallies(0, 0, 0);
    rst = 1'b0;
    m_lfsr = 16'hACE1;
    chk("midrst_sb_empty", 32'(exp_q.size()), 32'd0);
    issue(2'd0, 4, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) predict_slot(k);
    finish_run();
    chk_tallies(4, 0, 0);
    // zero-length run with start still high while in DONE
    issue(2'd0, 0, 1'b0, 1'b1);
    @(posedge clk);
    #1 start = 1'b0;
    chk("zero_done_once", 32'(done), 32'd0);
    chk("start_in_done_ignored", 32'(busy), 32'd0);
    @(posedge clk);
    #1 chk("zero_idle", {30'd0, busy, done}, 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("zero_no_reqs", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_stim_driver.md
Name: fifo_stim_driver

Overview:
- Synthesizable traffic generator that drives the write/read side of the FIFO interface.
- It sits where the bench's passive FIFO monitor observes the same signals.
- On a start pulse it issues a programmed number of write/read requests according to a mode. It also tallies the FIFO's handshake responses (wr_ack, overflow, underflow).
- Used for on-chip/emulation stress of the FIFO and as a reusable stimulus source for the existing monitor/scoreboard flow.

Parameters:
- FIFO_WIDTH, 16, data_in width.
- FIFO_DEPTH, 8, FIFO depth; used only for the FILL_DRAIN phase switch.
- LFSR_SEED, 16'hACE1, reset value of the internal LFSR. A value of 0 is illegal and is replaced by 16'hACE1.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a run; ignored while busy.
- mode  in  2  0=WRITE_ONLY, 1=READ_ONLY, 2=FILL_DRAIN, 3=RANDOM; latched on start.
- num_ops  in  16  number of request cycles to issue; latched on start.
- guard  in  1  1=suppress wr_en when full and rd_en when empty; latched on start.
- full, empty  in  1 each  FIFO status.
- wr_ack, overflow, underflow  in  1 each  FIFO registered responses.
- wr_en, rd_en  out  1 each  FIFO requests.
- data_in  out  FIFO_WIDTH  write data.
- busy  out  1  high from the cycle after start through DRAIN.
- done  out  1  one-cycle pulse at end of run.
- ack_count, ovf_count, udf_count  out  16 each  saturating response tallies.

Behaviour:
- Reset (any cycle, including mid-run):
  - state=IDLE.
  - wr_en, rd_en, data_in, busy, done = 0.
  - All counters = 0.
  - LFSR = seed.
  - Takes effect at the same edge; no residual requests.
- States: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start=1 latches mode/num_ops/guard, clears the three tallies and the op counter, and sets busy.
  - Next state is RUN, or DONE directly if num_ops==0 (zero requests issued).
- RUN: one request slot per cycle; op counter increments each slot. Requests are registered, so wr_en/rd_en appear the cycle after the decision.
  - WRITE_ONLY: wr_en=1, rd_en=0.
  - READ_ONLY: wr_en=0, rd_en=1.
  - FILL_DRAIN: first FIFO_DEPTH slots write, next FIFO_DEPTH read, repeating.
  - RANDOM: wr_en = (lfsr[1:0]!=0), i.e. 75%; rd_en = (lfsr[3:2]==0), i.e. 25%. Simultaneous wr/rd is allowed.
- Guard:
  - guard=1 masks wr_en when full=1 and rd_en when empty=1, using flag values sampled the same cycle.
  - A masked slot still counts as an op, so the run length is always num_ops cycles.
  - guard=0 deliberately provokes overflow/underflow.
- Write data: data_in = {write index} (16-bit counter from 0, incrementing per asserted wr_en, truncated or zero-extended to FIFO_WIDTH). In RANDOM mode, data_in = lfsr zero-extended or truncated instead. data_in holds when wr_en=0.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every RUN cycle only.
- Run end: after the num_ops-th slot, go to DRAIN with wr_en=rd_en=0.
  - DRAIN lasts 2 cycles so the registered FIFO responses to the last request are counted.
  - Then DONE: done=1 for exactly one cycle, busy=0, and the state returns to IDLE.
- Tallies:
  - Each counts cycles in RUN or DRAIN where the corresponding input is 1.
  - Saturate at 16'hFFFF.
  - Hold their value after DONE until the next accepted start.
- start asserted in DONE is ignored; it is accepted the following cycle in IDLE.

Decomposition:
- Shared package fifo_drv_pkg holds:
  - mode_e enum (WRITE_ONLY, READ_ONLY, FILL_DRAIN, RANDOM).
  - state_e enum (IDLE, RUN, DRAIN, DONE).
  - DEFAULT_SEED constant and DRAIN_CYCLES=2.
- One sub-module: fifo_drv_lfsr (16-bit LFSR with enable and seed load).

Test Plan:
- WRITE_ONLY, num_ops=10, guard=0, into an empty depth-8 FIFO -> data_in 0..9 on consecutive cycles; ack_count=8, ovf_count=2, udf_count=0, done one cycle after DRAIN.
- READ_ONLY, num_ops=3, guard=0, empty FIFO -> udf_count=3, ack_count=0; with guard=1 -> rd_en never asserted, udf_count=0, done still after 3+2 cycles.
- FILL_DRAIN, num_ops=16, guard=1 -> 8 writes (data 0..7) then 8 reads; ack_count=8, ovf=0, udf=0; FIFO empty at done.
- RANDOM, num_ops=1000, seed 16'hACE1, guard=1 -> no overflow/underflow; wr_en count matches the LFSR reference model exactly (bit-accurate).
- rst asserted at op 5 of a WRITE_ONLY run of 20 -> wr_en=0 and busy=0 the same edge, tallies 0; a new start then runs cleanly with data restarting at 0.
- num_ops=0 start -> no wr_en/rd_en; done pulses 1 cycle after start; start during busy is ignored.
